seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the combinational array-multiplier cells in the multiplier datapath. One partial-product/adder slice is reused over WIDTH clock cycles, so an N×N product costs one W-bit adder instead of an N² cell array. A start/busy/done handshake connects it to a controller. A mode input selects unsigned or two's-complement signed operands.

---
 rtl/seq_multiplier_if.sv | 29 ++
 rtl/seq_multiplier.sv | 104 ++++++++++
 tb/tb_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Controller-to-multiplier bus: operand request plus busy/done/product status.
//
// Handshake: the master raises start with mult_a, mult_b and signed_mode valid
// in the same cycle. The slave accepts on a rising edge only when it is neither
// busy nor mid-result (idle or presenting done). A start seen while busy is
// dropped without effect. done pulses for exactly one cycle when product
// becomes valid, and product then holds until the next accepted start.
// busy and done are never high together.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     mult_a;
    logic [WIDTH-1:0]     mult_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, mult_a, mult_b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, mult_a, mult_b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier. One WIDTH-bit adder is reused over WIDTH
// cycles; signed operands are converted to magnitudes on acceptance and the
// result is negated on the final step when the operand signs differ.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_multiplier_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Adder slice result (with carry) and the shifted accumulator for this step
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_mag_q   <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: acceptance, one shift-add step per cycle, final sign fix
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        // Add the multiplicand into the upper half when the multiplier LSB is set,
        // then shift {carry, accumulator} right by one.
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + ({1'b0, a_mag_q} & {(WIDTH+1){b_q[0]}});
        acc_step = {sum, acc_q[WIDTH-1:1]};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // Magnitudes are kept unsigned so -2^(WIDTH-1) stays representable
                    a_mag_d = (bus.signed_mode && bus.mult_a[WIDTH-1]) ? -bus.mult_a : bus.mult_a;
                    b_d     = (bus.signed_mode && bus.mult_b[WIDTH-1]) ? -bus.mult_b : bus.mult_b;
                    neg_d   = bus.signed_mode & (bus.mult_a[WIDTH-1] ^ bus.mult_b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    product_d = neg_q ? -acc_step : acc_step;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register
    assign bus.busy    = (state_q == ST_CALC);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.product = product_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=8 and a WIDTH=4 instance driven by
// directed vectors, with expected products queued at issue time and checked
// by independent monitors when done pulses.
module tb_seq_multiplier;
    logic clk;
    logic rst_n;
    logic [1:0] dbg8;
    logic [1:0] dbg4;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q8[$];
    logic [7:0]  exp_q4[$];
    int busy_cnt8 = 0;
    int busy_cnt4 = 0;

    seq_multiplier_if #(.WIDTH(8)) bus8 ();
    seq_multiplier_if #(.WIDTH(4)) bus4 ();

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus8.slave),
        .dbg_state_o (dbg8)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus4.slave),
        .dbg_state_o (dbg4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (bus8.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL issue8_timeout busy stuck high, required low");
        end
        bus8.start       = 1'b1;
        bus8.signed_mode = sm;
        bus8.mult_a      = a;
        bus8.mult_b      = b;
        if (push) exp_q8.push_back(exp);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic issue4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (bus4.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL issue4_timeout busy stuck high, required low");
        end
        bus4.start       = 1'b1;
        bus4.signed_mode = sm;
        bus4.mult_a      = a;
        bus4.mult_b      = b;
        exp_q4.push_back(exp);
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q8.size() != 0 || exp_q4.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL %s_drain pending=%0d/%0d required 0/0", tag, exp_q8.size(), exp_q4.size());
            exp_q8.delete();
            exp_q4.delete();
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", tag, act, req);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            busy_cnt8 = 0;
        end else begin
            if (bus8.busy) busy_cnt8++;
            if (bus8.done) begin
                checks++;
                if (exp_q8.size() == 0) begin
                    errors++;
                    $display("FAIL done8_unexpected product=%h required no done", bus8.product);
                end else begin
                    e = exp_q8.pop_front();
                    if (bus8.product !== e) begin
                        errors++;
                        $display("FAIL product8 got=%h required=%h", bus8.product, e);
                    end
                end
                checks++;
                if (busy_cnt8 != 8 || bus8.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy8_len got=%0d busy_at_done=%b required=8/0", busy_cnt8, bus8.busy);
                end
                busy_cnt8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            busy_cnt4 = 0;
        end else begin
            if (bus4.busy) busy_cnt4++;
            if (bus4.done) begin
                checks++;
                if (exp_q4.size() == 0) begin
                    errors++;
                    $display("FAIL done4_unexpected product=%h required no done", bus4.product);
                end else begin
                    e = exp_q4.pop_front();
                    if (bus4.product !== e) begin
                        errors++;
                        $display("FAIL product4 got=%h required=%h", bus4.product, e);
                    end
                end
                checks++;
                if (busy_cnt4 != 4 || bus4.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy4_len got=%0d busy_at_done=%b required=4/0", busy_cnt4, bus4.busy);
                end
                busy_cnt4 = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0]  cont_a [3];
    logic [7:0]  cont_b [3];
    logic [15:0] cont_p [3];

    initial begin
        cont_a[0] = 8'd13;  cont_b[0] = 8'd11; cont_p[0] = 16'd143;
        cont_a[1] = 8'd200; cont_b[1] = 8'd3;  cont_p[1] = 16'd600;
        cont_a[2] = 8'd17;  cont_b[2] = 8'd15; cont_p[2] = 16'd255;

        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.mult_a = '0; bus8.mult_b = '0;
        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.mult_a = '0; bus4.mult_b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check16("reset_busy",    {15'd0, bus8.busy}, 16'd0);
        check16("reset_done",    {15'd0, bus8.done}, 16'd0);
        check16("reset_product", bus8.product,       16'd0);
        rst_n = 1'b1;

        // unsigned maximum
        issue8(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1);
        // signed corner and mixed signs, then same bits unsigned
        issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
        issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1);
        issue8(1'b0, 8'hFD, 8'h05, 16'h04F1, 1'b1);
        wait_drain("basic");

        // start pulsed mid-calculation must be ignored
        issue8(1'b0, 8'd3, 8'd4, 16'd12, 1'b1);
        repeat (3) @(negedge clk);
        bus8.start = 1'b1; bus8.mult_a = 8'd7; bus8.mult_b = 8'd9;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_drain("ignore");
        repeat (4) @(negedge clk);
        check16("product_hold", bus8.product, 16'd12);

        // start held high with operands changing every cycle
        for (int i = 0; i < 27; i++) begin
            if (i % 9 == 0) begin
                bus8.mult_a = cont_a[i/9];
                bus8.mult_b = cont_b[i/9];
                exp_q8.push_back(cont_p[i/9]);
            end else begin
                bus8.mult_a = 8'(i + 40);
                bus8.mult_b = 8'(i * 5 + 1);
            end
            bus8.signed_mode = 1'b0;
            bus8.start       = 1'b1;
            @(negedge clk);
        end
        bus8.start = 1'b0;
        wait_drain("continuous");

        // asynchronous reset in the middle of a calculation
        issue8(1'b0, 8'd9, 8'd9, 16'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check16("midreset_busy",    {15'd0, bus8.busy}, 16'd0);
        check16("midreset_done",    {15'd0, bus8.done}, 16'd0);
        check16("midreset_product", bus8.product,       16'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        issue8(1'b0, 8'd2, 8'd3, 16'd6, 1'b1);
        wait_drain("after_reset");

        // WIDTH=4 instance: zero operand with most-negative, then squared corner
        issue4(1'b1, 4'h0, 4'h8, 8'h00);
        issue4(1'b1, 4'h8, 4'h8, 8'h40);
        issue4(1'b0, 4'hF, 4'hF, 8'hE1);
        wait_drain("width4");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
